// File: rtl/sprite_bounce_blitter_if.sv
// Plot/ROM bundle between the sprite blitter and its parent.
//   enable, fg_colour, bg_colour : parent -> blitter control and colours
//   rom_addr / rom_q             : sprite ROM lookup (rom_q one cycle after rom_addr)
//   vga_x, vga_y, vga_colour,
//   vga_plot                     : pixel write port toward vga_adapter
//   busy, frame_done             : frame status
// The master modport is the parent side (it owns the ROM); slave is the blitter.
interface sprite_bounce_blitter_if #(
  parameter int CBITS = 3,
  parameter int AW    = 8
);
  logic             enable;
  logic [CBITS-1:0] fg_colour;
  logic [CBITS-1:0] bg_colour;
  logic [AW-1:0]    rom_addr;
  logic             rom_q;
  logic [7:0]       vga_x;
  logic [6:0]       vga_y;
  logic [CBITS-1:0] vga_colour;
  logic             vga_plot;
  logic             busy;
  logic             frame_done;

  modport master (
    output enable, fg_colour, bg_colour, rom_q,
    input  rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, frame_done
  );

  modport slave (
    input  enable, fg_colour, bg_colour, rom_q,
    output rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, frame_done
  );
endinterface

// File: rtl/sprite_bounce_blitter.sv
// Bounces a monochrome ROM sprite around the screen. On each enabled frame
// tick it erases the sprite at its old position, moves it, and redraws it,
// writing one pixel per cycle to the vga_adapter plot port.
//   CLOCK_50 : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : sprite_bounce_blitter_if.slave (controls, ROM port, plot port, status)
//
// state | meaning
// IDLE  | waiting for a frame tick with enable high
// ERASE | plotting bg_colour over the old sprite rectangle
// MOVE  | one cycle: step position, bounce off edges
// DRAW  | walking ROM addresses; plots trail by one cycle
// FLUSH | last drawn pixel plotted, frame_done pulsed
module sprite_bounce_blitter #(
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int SPR_W     = 16,
  parameter int SPR_H     = 16,
  parameter int X_INIT    = 0,
  parameter int Y_INIT    = 60,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 833334,
  parameter int CBITS     = 3,
  parameter int AW        = 8
) (
  input logic                    CLOCK_50,
  input logic                    reset_n,
  sprite_bounce_blitter_if.slave bus
);
  localparam int            TW        = $clog2(FRAME_DIV + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(FRAME_DIV - 1);
  localparam logic [7:0]    COL_LAST  = 8'(SPR_W - 1);
  localparam logic [6:0]    ROW_LAST  = 7'(SPR_H - 1);
  localparam logic [8:0]    MAX_X     = 9'(SCREEN_W - SPR_W);
  localparam logic [8:0]    MAX_Y     = 9'(SCREEN_H - SPR_H);
  localparam logic [8:0]    STEP9     = 9'(STEP);
  localparam logic [7:0]    STEP_X    = 8'(STEP);
  localparam logic [6:0]    STEP_Y    = 7'(STEP);

  typedef enum logic [2:0] {IDLE, ERASE, MOVE, DRAW, FLUSH} state_t;
  state_t state, state_nx;

  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [7:0]       pos_x;
  logic [6:0]       pos_y;
  logic             dir_x_pos, dir_y_pos;
  logic             drawn;
  logic [7:0]       col;
  logic [6:0]       row;
  logic             scan_last;
  logic [AW-1:0]    addr;
  logic             pix_plot;
  logic [7:0]       pix_x;
  logic [6:0]       pix_y;
  logic [8:0]       x_up, y_up;
  logic [7:0]       x_nx;
  logic [6:0]       y_nx;
  logic             dx_nx, dy_nx;
  logic             plot;
  logic [7:0]       out_x;
  logic [6:0]       out_y;
  logic [CBITS-1:0] out_colour;

  // Free-running frame divider, independent of the FSM.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)  tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end
  assign tick = (tick_cnt == TICK_LAST);

  assign scan_last = (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    plot       = 1'b0;
    out_x      = '0;
    out_y      = '0;
    out_colour = '0;
    case (state)
      IDLE:    if (tick && bus.enable) state_nx = drawn ? ERASE : DRAW;
      ERASE:   if (scan_last) state_nx = MOVE;
      MOVE:    state_nx = DRAW;
      DRAW:    if (scan_last) state_nx = FLUSH;
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (state == ERASE) begin
      plot       = 1'b1;
      out_x      = pos_x + col;
      out_y      = pos_y + row;
      out_colour = bus.bg_colour;
    end else if (pix_plot) begin
      // Colour is picked live so a colour change lands on the next pixel.
      plot       = 1'b1;
      out_x      = pix_x;
      out_y      = pix_y;
      out_colour = bus.rom_q ? bus.fg_colour : bus.bg_colour;
    end
  end

  // Bounce arithmetic carried at 9 bits so pos+STEP never wraps.
  always_comb begin
    x_up  = {1'b0, pos_x} + STEP9;
    y_up  = {2'b0, pos_y} + STEP9;
    x_nx  = pos_x;
    y_nx  = pos_y;
    dx_nx = dir_x_pos;
    dy_nx = dir_y_pos;
    if (dir_x_pos) begin
      if (x_up > MAX_X) begin x_nx = MAX_X[7:0]; dx_nx = 1'b0; end
      else              x_nx = x_up[7:0];
    end else if (pos_x < STEP_X) begin
      x_nx = '0; dx_nx = 1'b1;
    end else begin
      x_nx = pos_x - STEP_X;
    end
    if (dir_y_pos) begin
      if (y_up > MAX_Y) begin y_nx = MAX_Y[6:0]; dy_nx = 1'b0; end
      else              y_nx = y_up[6:0];
    end else if (pos_y < STEP_Y) begin
      y_nx = '0; dy_nx = 1'b1;
    end else begin
      y_nx = pos_y - STEP_Y;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pos_x     <= 8'(X_INIT);
      pos_y     <= 7'(Y_INIT);
      dir_x_pos <= 1'b1;
      dir_y_pos <= 1'b0;
      drawn     <= 1'b0;
      col       <= '0;
      row       <= '0;
      addr      <= '0;
      pix_plot  <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
    end else begin
      // Draw coordinates ride one cycle behind the ROM address to meet rom_q.
      pix_plot <= (state == DRAW);
      pix_x    <= pos_x + col;
      pix_y    <= pos_y + row;
      if (state == ERASE || state == DRAW) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (state == DRAW && !scan_last) addr <= addr + 1'b1;
      if (state_nx == DRAW && state != DRAW) addr <= '0;
      if (state == MOVE) begin
        pos_x     <= x_nx;
        pos_y     <= y_nx;
        dir_x_pos <= dx_nx;
        dir_y_pos <= dy_nx;
      end
      if (state == FLUSH) drawn <= 1'b1;
    end
  end

  assign bus.rom_addr   = addr;
  assign bus.vga_plot   = plot;
  assign bus.vga_x      = out_x;
  assign bus.vga_y      = out_y;
  assign bus.vga_colour = out_colour;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = (state == FLUSH);
endmodule

// File: tb/tb_sprite_bounce_blitter.sv
module tb_sprite_bounce_blitter;
  localparam int NC = 3;
  localparam int C_SW[NC] = '{160, 24, 160};
  localparam int C_SH[NC] = '{120, 14, 120};
  localparam int C_PW[NC] = '{16, 5, 16};
  localparam int C_PH[NC] = '{16, 3, 16};
  localparam int C_XI[NC] = '{0, 17, 144};
  localparam int C_YI[NC] = '{60, 2, 0};
  localparam int C_ST[NC] = '{1, 3, 1};
  localparam int C_FD[NC] = '{1000, 40, 600};

  typedef struct {
    int x;
    int y;
    bit fg;
    bit last;
    int idx;
  } pix_t;

  logic     CLOCK_50 = 1'b0;
  logic     reset_n  = 1'b0;
  bit       en[NC];
  logic [2:0] fg[NC];
  logic [2:0] bg[NC];
  int       errors = 0;
  int       checks = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NC; g++) begin : u
    localparam int SW = C_SW[g];
    localparam int SH = C_SH[g];
    localparam int PW = C_PW[g];
    localparam int PH = C_PH[g];
    localparam int XI = C_XI[g];
    localparam int YI = C_YI[g];
    localparam int ST = C_ST[g];
    localparam int FD = C_FD[g];
    localparam int N  = PW * PH;

    sprite_bounce_blitter_if #(.CBITS(3), .AW(8)) bus ();

    sprite_bounce_blitter #(
      .SCREEN_W(SW), .SCREEN_H(SH), .SPR_W(PW), .SPR_H(PH),
      .X_INIT(XI), .Y_INIT(YI), .STEP(ST), .FRAME_DIV(FD),
      .CBITS(3), .AW(8)
    ) dut (
      .CLOCK_50(CLOCK_50),
      .reset_n (reset_n),
      .bus     (bus)
    );

    assign bus.enable    = en[g];
    assign bus.fg_colour = fg[g];
    assign bus.bg_colour = bg[g];

    // Synchronous sprite ROM: q = addr[0].
    always @(posedge CLOCK_50) bus.rom_q <= bus.rom_addr[0];

    pix_t q[$];
    pix_t p;
    int px, py, dx, dy, drawn_m, cnt, busy_left;
    int last_draw_idx = -1;

    task automatic start_frame();
      if (drawn_m != 0) begin
        for (int r = 0; r < PH; r++)
          for (int c = 0; c < PW; c++)
            q.push_back('{x: px + c, y: py + r, fg: 1'b0, last: 1'b0, idx: -1});
        if (dx > 0) begin
          if (px + ST > SW - PW) begin px = SW - PW; dx = -1; end
          else px = px + ST;
        end else begin
          if (px < ST) begin px = 0; dx = 1; end
          else px = px - ST;
        end
        if (dy > 0) begin
          if (py + ST > SH - PH) begin py = SH - PH; dy = -1; end
          else py = py + ST;
        end else begin
          if (py < ST) begin py = 0; dy = 1; end
          else py = py - ST;
        end
        busy_left = 2 * N + 2;
      end else begin
        busy_left = N + 1;
      end
      for (int k = 0; k < N; k++)
        q.push_back('{x: px + k % PW, y: py + k / PW, fg: bit'(k % 2),
                      last: (k == N - 1), idx: k});
      drawn_m = 1;
    endtask

    // Reference model: frame ticks and expected pixel stream.
    always @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
        q.delete();
        px = XI; py = YI; dx = 1; dy = -1;
        drawn_m = 0; cnt = 0; busy_left = 0;
      end else begin
        if (busy_left > 0) busy_left--;
        if (cnt == FD - 1) begin
          cnt = 0;
          if (en[g]) start_frame();
        end else begin
          cnt++;
        end
      end
    end

    // Monitor: pops the scoreboard on every plot.
    always @(negedge CLOCK_50) begin
      if (!reset_n) begin
        chk($sformatf("c%0d reset plot", g), bus.vga_plot, 0);
        chk($sformatf("c%0d reset x", g), bus.vga_x, 0);
        chk($sformatf("c%0d reset y", g), bus.vga_y, 0);
        chk($sformatf("c%0d reset colour", g), bus.vga_colour, 0);
        chk($sformatf("c%0d reset busy", g), bus.busy, 0);
        chk($sformatf("c%0d reset done", g), bus.frame_done, 0);
        chk($sformatf("c%0d reset addr", g), bus.rom_addr, 0);
      end else begin
        chk($sformatf("c%0d busy", g), bus.busy, int'(busy_left > 0));
        if (busy_left == 0)
          chk($sformatf("c%0d missing plots", g), q.size(), 0);
        if (bus.vga_plot) begin
          if (q.size() == 0) begin
            chk($sformatf("c%0d unexpected plot", g), bus.vga_plot, 0);
          end else begin
            p = q.pop_front();
            chk($sformatf("c%0d x idx%0d", g, p.idx), bus.vga_x, p.x);
            chk($sformatf("c%0d y idx%0d", g, p.idx), bus.vga_y, p.y);
            chk($sformatf("c%0d colour idx%0d", g, p.idx), bus.vga_colour,
                p.fg ? fg[g] : bg[g]);
            chk($sformatf("c%0d frame_done idx%0d", g, p.idx), bus.frame_done, p.last);
            if (p.idx >= 0) last_draw_idx = p.idx;
          end
        end else begin
          chk($sformatf("c%0d frame_done idle", g), bus.frame_done, 0);
        end
      end
    end
  end

  task automatic new_colours(input int i);
    bg[i] = 3'($urandom_range(7));
    fg[i] = bg[i] ^ 3'($urandom_range(7, 1));
  endtask

  // One cycle per iteration; inputs change just after the rising edge.
  task automatic run_cycles(input int n, input bit force0, input bit v0);
    for (int c = 0; c < n; c++) begin
      @(posedge CLOCK_50);
      #1;
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(63) == 0) new_colours(i);
        if (i == 0 && force0) en[i] = v0;
        else                  en[i] = ($urandom_range(7) != 0);
      end
    end
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < NC; i++) begin
      en[i] = 1'b0;
      new_colours(i);
    end
    reset_n = 1'b0;
    repeat (5) @(posedge CLOCK_50);
    #1 reset_n = 1'b1;

    // First frames on all instances: draw-only, then erase/move/draw.
    run_cycles(3200, 1'b1, 1'b1);
    run_cycles(3000, 1'b0, 1'b0);
    // Enable held low on instance 0 across three ticks, then back on.
    run_cycles(3000, 1'b1, 1'b0);
    run_cycles(3000, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a draw on instance 0.
    u[0].last_draw_idx = -1;
    hit = 1'b0;
    for (int c = 0; c < 2500 && !hit; c++) begin
      run_cycles(1, 1'b1, 1'b1);
      if (u[0].last_draw_idx == 99) hit = 1'b1;
    end
    chk("reset trigger reached draw 99", u[0].last_draw_idx, 99);
    reset_n = 1'b0;
    #1;
    chk("plot low at reset", u[0].bus.vga_plot, 0);
    chk("busy low at reset", u[0].bus.busy, 0);
    repeat (3) @(posedge CLOCK_50);
    #1 reset_n = 1'b1;
    run_cycles(3000, 1'b1, 1'b1);
    run_cycles(2000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
